// File: rtl/memresponder.sv
// memresponder: single-port word memory with a fixed-latency request/response handshake.
//
// One request is accepted in IDLE. LATENCY wait cycles follow, then a one-cycle RESP
// in which ready pulses. The access is committed on the edge that enters RESP, so ready
// rises on the (LATENCY+1)th edge counting the accepting edge. Request inputs are ignored
// outside IDLE; the values captured at acceptance govern the whole transaction.
//
// Parameters
//   LATENCY  wait cycles between acceptance and response (0..15)
//   DEPTH    number of 32-bit words, word index = addr[31:2]
// Ports
//   clk      clock, rising edge
//   reset    asynchronous active-high reset (array contents are not cleared)
//   req      request strobe, sampled in IDLE
//   we       1 = write, 0 = read, sampled with req
//   addr     byte address, sampled with req
//   wdata    write data, sampled with req
//   rdata    read data, valid while ready=1, otherwise 0
//   ready    one-cycle response strobe
//   err      misaligned or out-of-range address, qualified by ready
module memresponder #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LoadVal = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        cap_we_q;
  logic [31:0] cap_addr_q;
  logic [31:0] cap_wdata_q;

  logic [31:0] mem [DEPTH];

  // The operation that completes on the coming edge. With zero latency it completes on the
  // accepting edge itself, so it must come from the live inputs rather than the capture regs.
  logic          enter_resp;
  logic          op_we;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic          op_legal;
  logic [AW-1:0] op_idx;
  logic          mem_wr;

  always_comb begin
    enter_resp = 1'b0;
    op_we      = cap_we_q;
    op_addr    = cap_addr_q;
    op_wdata   = cap_wdata_q;
    if ((state_q == StIdle) && req && (LATENCY == 0)) begin
      enter_resp = 1'b1;
      op_we      = we;
      op_addr    = addr;
      op_wdata   = wdata;
    end else if ((state_q == StWait) && (cnt_q == 4'd0)) begin
      enter_resp = 1'b1;
    end
  end

  assign op_legal = (op_addr[1:0] == 2'b00) && ({2'b00, op_addr[31:2]} < DEPTH);
  assign op_idx   = op_addr[AW+1:2];
  // Gating with reset keeps an aborted transaction from reaching the array.
  assign mem_wr   = enter_resp && op_we && op_legal && !reset;

  // Array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[op_idx] <= op_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= 32'd0;
      cap_wdata_q <= 32'd0;
      ready       <= 1'b0;
      err         <= 1'b0;
      rdata       <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            cap_we_q    <= we;
            cap_addr_q  <= addr;
            cap_wdata_q <= wdata;
            cnt_q       <= LoadVal;
            state_q     <= (LATENCY == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      // Outputs are nonzero only in the cycle following enter_resp, i.e. while in RESP.
      ready <= enter_resp;
      err   <= enter_resp && !op_legal;
      rdata <= (enter_resp && op_legal && !op_we) ? mem[op_idx] : 32'd0;
    end
  end

endmodule

// File: tb/tb_memresponder.sv
// Self-checking bench for memresponder: one LATENCY=2 and one LATENCY=0 instance, directed
// scenarios followed by randomized transactions checked against an array reference model.
module tb_memresponder;

  logic        clk;
  logic        reset;

  logic        req2, we2;
  logic [31:0] addr2, wdata2, rdata2;
  logic        ready2, err2;

  logic        req0, we0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, err0;

  int vectors = 0;
  int errors  = 0;

  // Reference model: one word array per instance, plus a written-flag per word.
  logic [31:0] mm [2][64];
  bit          mv [2][64];

  memresponder #(.LATENCY(2), .DEPTH(64)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .req   (req2),
    .we    (we2),
    .addr  (addr2),
    .wdata (wdata2),
    .rdata (rdata2),
    .ready (ready2),
    .err   (err2)
  );

  memresponder #(.LATENCY(0), .DEPTH(64)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .req   (req0),
    .we    (we0),
    .addr  (addr0),
    .wdata (wdata0),
    .rdata (rdata0),
    .ready (ready0),
    .err   (err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < 64);
  endfunction

  task automatic drive(input bit l0, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    if (l0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req2 = r; we2 = w; addr2 = a; wdata2 = d;
    end
  endtask

  task automatic check_out(input bit l0, input string tag, input logic rdy, input logic e,
                           input logic [31:0] rd, input bit chk_rd);
    check({tag, ".ready"}, l0 ? 32'(ready0) : 32'(ready2), 32'(rdy));
    check({tag, ".err"},   l0 ? 32'(err0)   : 32'(err2),   32'(e));
    if (chk_rd) check({tag, ".rdata"}, l0 ? rdata0 : rdata2, rd);
  endtask

  // One complete transaction; inputs are scrambled after acceptance to show they are ignored.
  task automatic txn(input bit l0, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input string tag);
    int          lat    = l0 ? 0 : 2;
    int          m      = l0 ? 1 : 0;
    logic        e_err  = !legal(a);
    logic [31:0] e_rd   = 32'd0;
    bit          chk_rd = 1'b1;
    if (!e_err) begin
      if (w) begin
        mm[m][a / 4] = d;
        mv[m][a / 4] = 1'b1;
      end else if (mv[m][a / 4]) begin
        e_rd = mm[m][a / 4];
      end else begin
        chk_rd = 1'b0;
      end
    end
    @(negedge clk);
    drive(l0, 1'b1, w, a, d);
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk);
      #1;
      drive(l0, 1'($urandom), 1'($urandom), $urandom, $urandom);
      if (k < lat + 1) check_out(l0, {tag, ".wait"}, 1'b0, 1'b0, 32'd0, 1'b1);
      else             check_out(l0, {tag, ".resp"}, 1'b1, e_err, e_rd, chk_rd);
    end
    @(posedge clk);
    #1;
    check_out(l0, {tag, ".after"}, 1'b0, 1'b0, 32'd0, 1'b1);
    drive(l0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel = $urandom_range(0, 9);
    logic [31:0] idx = 32'($urandom_range(0, 63));
    if (sel < 7)       return idx * 4;
    else if (sel == 7) return idx * 4 + 32'($urandom_range(1, 3));
    else if (sel == 8) return 32'($urandom_range(64, 1000)) * 4;
    else               return $urandom;
  endfunction

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    // Raise reset between clock edges: outputs must clear without a clock edge.
    #2 reset = 1'b1;
    #1;
    check_out(1'b0, "reset2", 1'b0, 1'b0, 32'd0, 1'b1);
    check_out(1'b1, "reset0", 1'b0, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Directed scenarios on the LATENCY=2 instance.
    txn(1'b0, 1'b1, 32'h10,  32'hDEADBEEF, "wr10");
    txn(1'b0, 1'b0, 32'h10,  32'h0,        "rd10");
    txn(1'b0, 1'b1, 32'h13,  32'h12345678, "wr13_misaligned");
    txn(1'b0, 1'b0, 32'h10,  32'h0,        "rd10_again");
    txn(1'b0, 1'b0, 32'h100, 32'h0,        "rd100_range");
    txn(1'b0, 1'b1, 32'h20,  32'h0BADF00D, "wr20_scrambled");
    txn(1'b0, 1'b0, 32'h20,  32'h0,        "rd20");
    txn(1'b0, 1'b1, 32'h24,  32'h0,        "preload24");

    // Reset during WAIT of a write: aborted, no ready pulse, no array write.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h24, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #2 reset = 1'b1;
    #1;
    check_out(1'b0, "rst_wait", 1'b0, 1'b0, 32'd0, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_out(1'b0, "rst_hold", 1'b0, 1'b0, 32'd0, 1'b1);
    end
    @(negedge clk);
    reset = 1'b0;
    txn(1'b0, 1'b0, 32'h24, 32'h0, "rd24_after_abort");

    // Reset while in RESP: ready and rdata must drop immediately.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_out(1'b0, "pre_rst_resp", 1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_out(1'b0, "rst_resp", 1'b0, 1'b0, 32'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      txn(1'b0, 1'($urandom), rand_addr(), $urandom, $sformatf("rnd2_%0d", i));
    end

    // LATENCY=0 instance: directed, then continuous req.
    txn(1'b1, 1'b1, 32'h10, 32'hA5A5_5A5A, "l0_wr10");
    txn(1'b1, 1'b0, 32'h10, 32'h0,         "l0_rd10");
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i % 2 == 0) check_out(1'b1, $sformatf("b2b_%0d", i), 1'b1, 1'b0, 32'hA5A5_5A5A, 1'b1);
      else            check_out(1'b1, $sformatf("b2b_%0d", i), 1'b0, 1'b0, 32'd0, 1'b1);
    end
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

    for (int i = 0; i < 25; i++) begin
      txn(1'b1, 1'($urandom), rand_addr(), $urandom, $sformatf("rnd0_%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Safety net: never hang.
  initial begin
    #500000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memresponder.md
MEMRESPONDER -- requirements
Module: memresponder

Interface
REQ-001 SHALL have parameter LATENCY, default 2: wait cycles inserted between request acceptance and response; legal range 0..15.
REQ-002 SHALL have parameter DEPTH, default 64: number of 32-bit words in the array, addressed by addr[7:2].
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 1 bit: request strobe from the processor-side initiator.
REQ-006 SHALL have port we, input, 1 bit: 1 means write, 0 means read; sampled with req.
REQ-007 SHALL have port addr, input, 32 bits: byte address; sampled with req.
REQ-008 SHALL have port wdata, input, 32 bits: write data; sampled with req.
REQ-009 SHALL have port rdata, output, 32 bits: read data, registered, valid while ready=1.
REQ-010 SHALL have port ready, output, 1 bit, registered: response strobe, high for exactly one cycle per accepted request.
REQ-011 SHALL have port err, output, 1 bit, registered: error flag, qualified by ready.

Function
REQ-012 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-013 IDLE with req=1 at a rising edge: SHALL capture we, addr and wdata into internal registers, load the wait counter with LATENCY-1, and go to WAIT; if LATENCY=0, SHALL go directly to RESP.
REQ-014 WAIT: SHALL decrement the counter each edge; on the edge where the counter equals 0, SHALL go to RESP.
REQ-015 RESP: SHALL hold ready=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-016 SHALL raise ready on the (LATENCY+1)th rising edge, counting the accepting edge as the first.
REQ-017 SHALL ignore req, we, addr and wdata while in WAIT and RESP; the captured values govern the transaction.
REQ-018 If req is still 1 in the IDLE cycle that follows RESP, SHALL treat it as a new request; back-to-back throughput is one transaction per LATENCY+2 cycles.
REQ-019 Captured address is legal only if addr[1:0]=0 and the word index addr[31:2] < DEPTH.
REQ-020 Legal write: array word SHALL be updated on the edge entering RESP; rdata SHALL be 0 and err 0 in RESP.
REQ-021 Legal read: rdata SHALL equal the array word, registered on the edge entering RESP; err SHALL be 0.
REQ-022 Illegal address (misaligned or out of range): SHALL perform no array write, drive rdata=0 and err=1 in RESP, and keep the same latency.
REQ-023 A read following a write to the same word SHALL return the new data.
REQ-024 Outside RESP, ready and err SHALL be 0 and rdata SHALL hold 0.

Reset
REQ-025 reset=1 SHALL immediately force state IDLE, counter 0, ready=0, err=0, rdata=0 and clear the capture registers, independent of clk.
REQ-026 Reset in WAIT or RESP SHALL abort the transaction with no array write and no ready pulse.
REQ-027 Array contents SHALL NOT be cleared by reset; they are undefined until written.
REQ-028 The first request SHALL be accepted on the first rising edge at which reset=0 and req=1.

Verification
REQ-029 LATENCY=2, write 0xDEADBEEF to 0x10, then read 0x10 -> each ready on the 3rd edge counted from acceptance; read returns rdata=0xDEADBEEF, err=0.
REQ-030 Write 0x12345678 to 0x13 (misaligned) -> err=1, rdata=0; a subsequent read of 0x10 still returns 0xDEADBEEF.
REQ-031 Read 0x100 (index 64 >= DEPTH) -> err=1 and rdata=0 with normal latency.
REQ-032 Write to 0x20 accepted, change addr/wdata/we during WAIT -> write lands at 0x20 with the original data; readback confirms.
REQ-033 Assert reset during WAIT of a write of 0xCAFEF00D to 0x24 -> ready never pulses, outputs are 0 at once; a later read of 0x24 does not return 0xCAFEF00D if preloaded with 0x0.
REQ-034 Hold req=1 continuously with LATENCY=0 -> ready pulses every 2nd cycle, each pulse exactly 1 cycle wide.
